cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor-0 responder for the 5-stage MIPS pipeline. Executes the cp_oper commands the controller decodes: MFC0 read, MTC0 write, ERET.
- Owns the STATUS, CAUSE, EPC and EHBR registers and takes external interrupts.
- Issues a one-cycle PC redirect (jump_en/jump_addr) to the IF stage on interrupt entry and on ERET.
- Sits beside the EXE stage and commits on the EXE-stage enable.

Parameters:
- EHBR_RESET, 32'h0000_0100, reset value of the exception handler base register (handler entry address).
- INT_SYNC_STAGES, 2, synchroniser flops on ext_int; legal values 2..3.

Ports:
- clk  input  1  main clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  EXE stage enable; all state updates are gated by en
- exe_valid  input  1  EXE stage holds a real instruction (not a bubble)
- cp_oper  input  2  00 NONE, 01 STORE (MTC0), 10 ERET, 11 reserved (treated as NONE)
- addr_r  input  5  MFC0 source register number
- addr_w  input  5  MTC0 destination register number
- data_w  input  32  MTC0 write data (forwarded rt)
- pc_exe  input  32  PC of the instruction in EXE
- ext_int  input  1  asynchronous external interrupt request, level
- data_r  output  32  combinational read of register addr_r
- jump_en  output  1  one-cycle PC redirect request
- jump_addr  output  32  redirect target, valid when jump_en=1
- in_handler  output  1  FSM is in HANDLER

Behaviour:
- Register map:
  - 12 STATUS: bit0 IE, others read 0.
  - 13 CAUSE: bit31 int_pending (read-only), bits6:2 exccode, 0 = interrupt.
  - 14 EPC.
  - 15 EHBR.
  - All other addresses read 0; writes to them are ignored.
- Reset (rst_n=0, asynchronous): STATUS=0, CAUSE=0, EPC=0, EHBR=EHBR_RESET, synchroniser and pending flag cleared, FSM=RUN, jump_en=0, jump_addr=0, in_handler=0.
- ext_int passes through INT_SYNC_STAGES flops. A synchronised rising edge sets pending. pending clears only on interrupt entry.
- FSM states:
  - RUN -> HANDLER: when en & exe_valid & pending & IE & cp_oper!=ERET. Same edge: EPC<=pc_exe, CAUSE.exccode<=0, IE<=0, pending<=0. Next cycle: jump_en=1, jump_addr=EHBR.
  - HANDLER -> RUN: when en & exe_valid & cp_oper==ERET. Same edge: IE<=1. Next cycle: jump_en=1, jump_addr=EPC.
  - ERET in RUN: still redirects to EPC and sets IE; no state change.
- jump_en/jump_addr are registered: exactly one cycle high, latency 1 cycle after the committing edge.
- MTC0 commits at the edge with en & exe_valid & cp_oper==STORE.
- MTC0 and interrupt in the same cycle: MTC0 commits first, then the interrupt is taken using the new IE.
  - Writing IE=0 in that cycle suppresses the interrupt.
  - An MTC0 to EPC is overwritten by pc_exe.
- ERET and pending interrupt in the same cycle: ERET wins, and the interrupt is evaluated no earlier than the following cycle.
- MFC0 read is combinational, with no write-to-read bypass. A value written at edge N is visible from N+1.
- en=0: all state holds, including the pending flag (an edge still sets pending). jump_en is forced 0 while en=0 and any queued redirect is held.
- exe_valid=0 (bubble): no commit of any kind.
- Reset mid-redirect: the redirect is dropped and jump_en=0 immediately.

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined:
  - Adds COUNT (reg 9) and COMPARE (reg 11).
  - COUNT increments every clk while en=1, wrapping 32'hFFFF_FFFF->0.
  - When COUNT==COMPARE and COMPARE!=0, pending is set and CAUSE bit30 (timer) is set.
  - An MTC0 to COMPARE clears CAUSE bit30.
  - An MTC0 to COUNT overrides the increment for that cycle.
- Undefined: regs 9/11 read 0, writes are ignored, and CAUSE bit30 is always 0.

Test Plan:
1. Reset with EHBR_RESET=32'h100, then MFC0 addr_r=15 -> data_r=32'h100; addr_r=12 -> 0; no jump_en pulse.
2. MTC0 addr_w=12 data_w=1, then raise ext_int with exe_valid=1 and pc_exe=32'h40 -> after sync latency, EPC=32'h40, IE=0, in_handler=1, one-cycle jump_en with jump_addr=32'h100.
3. From HANDLER, ERET with exe_valid=1 -> next cycle jump_en=1, jump_addr=32'h40; IE=1; in_handler=0.
4. With pending set and IE=1, drive ERET and the pending interrupt in the same cycle -> only jump_addr=EPC that cycle; the interrupt is taken on the next valid instruction.
5. Interrupt with IE=1 while MTC0 writes STATUS=0 in the same cycle -> no entry and pending stays 1; later MTC0 STATUS=1 -> entry on that commit.
6. With CP0_TIMER_EN: MTC0 COUNT=32'hFFFF_FFFE, COMPARE=32'h1, IE=1 -> COUNT wraps through 0, pending sets at COUNT==1, CAUSE bit30=1, redirect to EHBR.

Source files
------------

// File: rtl/cp0_unit_if.sv
// Pipeline-side bus of the coprocessor-0 unit: EXE-stage command inputs,
// the read port and the PC redirect back to IF.
interface cp0_unit_if;
  logic        en;
  logic        exe_valid;
  logic [1:0]  cp_oper;
  logic [4:0]  addr_r;
  logic [4:0]  addr_w;
  logic [31:0] data_w;
  logic [31:0] pc_exe;
  logic        ext_int;
  logic [31:0] data_r;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        in_handler;

  modport master (
    output en, exe_valid, cp_oper, addr_r, addr_w, data_w, pc_exe, ext_int,
    input  data_r, jump_en, jump_addr, in_handler
  );

  modport slave (
    input  en, exe_valid, cp_oper, addr_r, addr_w, data_w, pc_exe, ext_int,
    output data_r, jump_en, jump_addr, in_handler
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the 5-stage MIPS pipeline: STATUS/CAUSE/EPC/EHBR, MFC0/MTC0/ERET,
// external interrupt entry. Define CP0_TIMER_EN to add the COUNT/COMPARE timer.
module cp0_unit #(
  parameter logic [31:0] EHBR_RESET      = 32'h0000_0100,
  parameter int unsigned INT_SYNC_STAGES = 2
) (
  input logic       clk,
  input logic       rst_n,
  cp0_unit_if.slave bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned EW = 5;

  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ERET  = 2'b10;

  localparam logic [AW-1:0] A_STATUS = AW'(12);
  localparam logic [AW-1:0] A_CAUSE  = AW'(13);
  localparam logic [AW-1:0] A_EPC    = AW'(14);
  localparam logic [AW-1:0] A_EHBR   = AW'(15);
`ifdef CP0_TIMER_EN
  localparam logic [AW-1:0] A_COUNT   = AW'(9);
  localparam logic [AW-1:0] A_COMPARE = AW'(11);
`endif

  typedef enum logic {S_RUN, S_HANDLER} state_t;

  state_t                     state_q, state_n;
  logic                       ie_q, ie_n;
  logic [EW-1:0]              exc_q, exc_n;
  logic [DW-1:0]              epc_q, epc_n;
  logic [DW-1:0]              ehbr_q, ehbr_n;
  logic                       pend_q, pend_n;
  logic                       jump_q, jump_n;
  logic [DW-1:0]              jaddr_q, jaddr_n;
  logic [INT_SYNC_STAGES-1:0] sync_q;
  logic                       sync_prev_q;
  logic                       int_rise;
  logic                       tmr_hit;
  logic                       tmr_bit;
  logic                       commit, store, eret, take;
  logic [DW-1:0]              rdata;

`ifdef CP0_TIMER_EN
  logic          tmr_q, tmr_n;
  logic [DW-1:0] count_q, count_n;
  logic [DW-1:0] compare_q, compare_n;

  assign tmr_hit = bus.en && (count_q == compare_q) && (compare_q != '0);
  assign tmr_bit = tmr_q;
`else
  assign tmr_hit = 1'b0;
  assign tmr_bit = 1'b0;
`endif

  assign int_rise = sync_q[INT_SYNC_STAGES-1] & ~sync_prev_q;
  assign commit   = bus.en & bus.exe_valid;
  assign store    = commit && (bus.cp_oper == OP_STORE);
  assign eret     = commit && (bus.cp_oper == OP_ERET);

  // Interrupt synchroniser runs free of en so edges are never lost during stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[INT_SYNC_STAGES-2:0], bus.ext_int};
      sync_prev_q <= sync_q[INT_SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      ie_q    <= 1'b0;
      exc_q   <= '0;
      epc_q   <= '0;
      ehbr_q  <= EHBR_RESET;
      pend_q  <= 1'b0;
      jump_q  <= 1'b0;
      jaddr_q <= '0;
    end else begin
      state_q <= state_n;
      ie_q    <= ie_n;
      exc_q   <= exc_n;
      epc_q   <= epc_n;
      ehbr_q  <= ehbr_n;
      pend_q  <= pend_n;
      jump_q  <= jump_n;
      jaddr_q <= jaddr_n;
    end
  end

`ifdef CP0_TIMER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q     <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      tmr_q     <= tmr_n;
      count_q   <= count_n;
      compare_q <= compare_n;
    end
  end
`endif

  // MTC0 is applied first so interrupt entry sees the freshly written IE/EPC/EHBR
  always_comb begin
    state_n = state_q;
    ie_n    = ie_q;
    exc_n   = exc_q;
    epc_n   = epc_q;
    ehbr_n  = ehbr_q;
    jump_n  = bus.en ? 1'b0 : jump_q;
    jaddr_n = jaddr_q;
`ifdef CP0_TIMER_EN
    count_n   = bus.en ? count_q + DW'(1) : count_q;
    compare_n = compare_q;
    tmr_n     = tmr_q | tmr_hit;
`endif

    if (store) begin
      unique case (bus.addr_w)
        A_STATUS: ie_n   = bus.data_w[0];
        A_CAUSE:  exc_n  = bus.data_w[6:2];
        A_EPC:    epc_n  = bus.data_w;
        A_EHBR:   ehbr_n = bus.data_w;
`ifdef CP0_TIMER_EN
        A_COUNT:  count_n = bus.data_w;
        A_COMPARE: begin
          compare_n = bus.data_w;
          tmr_n     = 1'b0;
        end
`endif
        default: ;
      endcase
    end

    take = commit && pend_q && ie_n && (bus.cp_oper != OP_ERET) && (state_q == S_RUN);

    pend_n = (pend_q & ~take) | int_rise | tmr_hit;

    if (take) begin
      state_n = S_HANDLER;
      epc_n   = bus.pc_exe;
      exc_n   = '0;
      ie_n    = 1'b0;
      jump_n  = 1'b1;
      jaddr_n = ehbr_n;
    end else if (eret) begin
      state_n = S_RUN;
      ie_n    = 1'b1;
      jump_n  = 1'b1;
      jaddr_n = epc_n;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (bus.addr_r)
      A_STATUS:  rdata = {31'b0, ie_q};
      A_CAUSE:   rdata = {pend_q, tmr_bit, 23'b0, exc_q, 2'b0};
      A_EPC:     rdata = epc_q;
      A_EHBR:    rdata = ehbr_q;
`ifdef CP0_TIMER_EN
      A_COUNT:   rdata = count_q;
      A_COMPARE: rdata = compare_q;
`endif
      default:   rdata = '0;
    endcase
  end

  // A queued redirect is held, not lost, while the stage is stalled
  assign bus.jump_en    = jump_q & bus.en;
  assign bus.jump_addr  = jaddr_q;
  assign bus.in_handler = (state_q == S_HANDLER);
  assign bus.data_r     = rdata;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed-vector bench for cp0_unit; define CP0_TIMER_EN to also exercise the timer.
module tb_cp0_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] r;
  int k;
  int n_vec = 0;
  int n_err = 0;

  cp0_unit_if bus();

  cp0_unit #(.EHBR_RESET(32'h0000_0100), .INT_SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one EXE-stage cycle, return at the following negedge
  task automatic step(input logic v, input logic [1:0] o, input logic [4:0] aw,
                      input logic [31:0] dw, input logic [31:0] pc);
    bus.exe_valid = v;
    bus.cp_oper   = o;
    bus.addr_w    = aw;
    bus.data_w    = dw;
    bus.pc_exe    = pc;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    bus.addr_r = a;
    #1;
    v = bus.data_r;
  endtask

  initial begin
    bus.en = 1'b1; bus.exe_valid = 1'b0; bus.cp_oper = 2'b00; bus.addr_r = 5'd0;
    bus.addr_w = 5'd0; bus.data_w = 32'h0; bus.pc_exe = 32'h0; bus.ext_int = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_jump_en", 32'(bus.jump_en), 32'h0);
    check("rst_in_handler", 32'(bus.in_handler), 32'h0);
    check("rst_jump_addr", bus.jump_addr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    rd(5'd15, r); check("ehbr_reset", r, 32'h100);
    rd(5'd12, r); check("status_reset", r, 32'h0);
    rd(5'd13, r); check("cause_reset", r, 32'h0);
    rd(5'd14, r); check("epc_reset", r, 32'h0);
    check("idle_jump_en", 32'(bus.jump_en), 32'h0);

    step(1'b0, 2'b01, 5'd15, 32'h300, 32'h0);
    rd(5'd15, r); check("bubble_no_write", r, 32'h100);

    bus.exe_valid = 1'b1; bus.cp_oper = 2'b01; bus.addr_w = 5'd12; bus.data_w = 32'h1;
    rd(5'd12, r); check("no_bypass", r, 32'h0);
    @(negedge clk);
    rd(5'd12, r); check("mtc0_status", r, 32'h1);
    idle();

`ifndef CP0_TIMER_EN
    step(1'b1, 2'b01, 5'd9, 32'hDEAD, 32'h0);
    step(1'b1, 2'b01, 5'd11, 32'h5, 32'h0);
    rd(5'd9, r);  check("count_absent", r, 32'h0);
    rd(5'd11, r); check("compare_absent", r, 32'h0);
`endif

    // Interrupt entry through the synchroniser
    bus.ext_int = 1'b1;
    bus.exe_valid = 1'b1; bus.cp_oper = 2'b00; bus.pc_exe = 32'h40;
    k = 0;
    while (!bus.in_handler && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("int_latency", 32'(k), 32'd4);
    check("int_jump_en", 32'(bus.jump_en), 32'h1);
    check("int_jump_addr", bus.jump_addr, 32'h100);
    idle();
    check("int_jump_one_cycle", 32'(bus.jump_en), 32'h0);
    rd(5'd14, r); check("int_epc", r, 32'h40);
    rd(5'd12, r); check("int_ie_clear", r, 32'h0);
    rd(5'd13, r); check("int_cause", r, 32'h0);
    bus.ext_int = 1'b0;

    // ERET from HANDLER
    step(1'b1, 2'b10, 5'd0, 32'h0, 32'h0);
    check("eret_jump_en", 32'(bus.jump_en), 32'h1);
    check("eret_jump_addr", bus.jump_addr, 32'h40);
    check("eret_in_handler", 32'(bus.in_handler), 32'h0);
    idle();
    check("eret_jump_one_cycle", 32'(bus.jump_en), 32'h0);
    rd(5'd12, r); check("eret_ie_set", r, 32'h1);

    // ERET beats a pending interrupt; the interrupt follows on the next instruction
    bus.ext_int = 1'b1;
    repeat (4) idle();
    rd(5'd13, r); check("pending_set", r, 32'h8000_0000);
    check("pending_no_entry_bubble", 32'(bus.in_handler), 32'h0);
    step(1'b1, 2'b10, 5'd0, 32'h0, 32'h0);
    check("eret_win_jump_addr", bus.jump_addr, 32'h40);
    check("eret_win_in_handler", 32'(bus.in_handler), 32'h0);
    rd(5'd13, r); check("eret_win_pending_kept", r, 32'h8000_0000);
    step(1'b1, 2'b00, 5'd0, 32'h0, 32'h80);
    check("after_eret_entry", 32'(bus.in_handler), 32'h1);
    check("after_eret_jump_en", 32'(bus.jump_en), 32'h1);
    check("after_eret_jump_addr", bus.jump_addr, 32'h100);
    rd(5'd14, r); check("after_eret_epc", r, 32'h80);
    bus.ext_int = 1'b0;
    step(1'b1, 2'b10, 5'd0, 32'h0, 32'h0);
    check("ret80_jump_addr", bus.jump_addr, 32'h80);
    idle();

    // MTC0 STATUS=0 in the interrupt cycle suppresses entry
    bus.ext_int = 1'b1;
    repeat (4) idle();
    step(1'b1, 2'b01, 5'd12, 32'h0, 32'hC0);
    check("suppress_in_handler", 32'(bus.in_handler), 32'h0);
    check("suppress_jump_en", 32'(bus.jump_en), 32'h0);
    rd(5'd13, r); check("suppress_pending", r, 32'h8000_0000);
    step(1'b1, 2'b01, 5'd12, 32'h1, 32'hC4);
    check("reenable_entry", 32'(bus.in_handler), 32'h1);
    check("reenable_jump_en", 32'(bus.jump_en), 32'h1);
    check("reenable_jump_addr", bus.jump_addr, 32'h100);
    rd(5'd14, r); check("reenable_epc", r, 32'hC4);
    idle();
    bus.ext_int = 1'b0;

    // Stall holds a queued redirect
    step(1'b1, 2'b10, 5'd0, 32'h0, 32'h0);
    bus.en = 1'b0; bus.exe_valid = 1'b0;
    #1 check("stall_jump_en", 32'(bus.jump_en), 32'h0);
    @(negedge clk);
    check("stall_hold_jump_en", 32'(bus.jump_en), 32'h0);
    bus.en = 1'b1;
    #1 check("release_jump_en", 32'(bus.jump_en), 32'h1);
    check("release_jump_addr", bus.jump_addr, 32'hC4);
    idle();
    check("release_one_cycle", 32'(bus.jump_en), 32'h0);

    // EHBR write, then reset mid-redirect
    step(1'b1, 2'b01, 5'd15, 32'h200, 32'h0);
    idle();
    rd(5'd15, r); check("ehbr_write", r, 32'h200);
    step(1'b1, 2'b10, 5'd0, 32'h0, 32'h0);
    check("pre_reset_jump_en", 32'(bus.jump_en), 32'h1);
    bus.exe_valid = 1'b0; bus.cp_oper = 2'b00;
    rst_n = 1'b0;
    #1 check("midreset_jump_en", 32'(bus.jump_en), 32'h0);
    check("midreset_jump_addr", bus.jump_addr, 32'h0);
    rd(5'd15, r); check("midreset_ehbr", r, 32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef CP0_TIMER_EN
    step(1'b1, 2'b01, 5'd12, 32'h1, 32'h0);
    step(1'b1, 2'b01, 5'd11, 32'h1, 32'h0);
    step(1'b1, 2'b01, 5'd9, 32'hFFFF_FFFE, 32'h0);
    rd(5'd9, r); check("count_write", r, 32'hFFFF_FFFE);
    idle();
    rd(5'd9, r); check("count_inc", r, 32'hFFFF_FFFF);
    k = 0;
    rd(5'd13, r);
    while (!r[31] && k < 10) begin
      idle();
      k++;
      rd(5'd13, r);
    end
    check("timer_latency", 32'(k), 32'd3);
    check("timer_cause", r, 32'hC000_0000);
    step(1'b1, 2'b00, 5'd0, 32'h0, 32'h1000);
    check("timer_entry", 32'(bus.in_handler), 32'h1);
    check("timer_jump_addr", bus.jump_addr, 32'h100);
    step(1'b1, 2'b01, 5'd11, 32'h2, 32'h0);
    rd(5'd13, r); check("timer_cause_clear", r, 32'h0);
    idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
